// File: rtl/aska_spi_readback_pkg.sv
// rtl/aska_spi_readback_pkg.sv - shared constants and types for the ASKA SPI readback path
package aska_spi_readback_pkg;

  localparam int HDR_BITS   = 8;
  localparam int DATA_BITS  = 32;
  localparam int FRAME_BITS = HDR_BITS + DATA_BITS;
  localparam int CNT_W      = 6;

  localparam int IC_ADDR_MSB = 7;
  localparam int IC_ADDR_LSB = 6;
  localparam int RD_BIT      = 5;
  localparam int REG_MSB     = 1;
  localparam int REG_LSB     = 0;

  localparam logic [1:0] REG_CONF0 = 2'd0;
  localparam logic [1:0] REG_CONF1 = 2'd1;
  localparam logic [1:0] REG_ELE1  = 2'd2;
  localparam logic [1:0] REG_ELE2  = 2'd3;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_TX   = 2'd1,
    ST_DONE = 2'd2,
    ST_IGN  = 2'd3
  } state_e;

  // A header addresses us for readback only if both the strap address and RD match.
  function automatic logic hdr_selects_read(input logic [HDR_BITS-1:0] hdr,
                                            input logic [1:0]          ic_addr);
    return (hdr[IC_ADDR_MSB:IC_ADDR_LSB] == ic_addr) && hdr[RD_BIT];
  endfunction

endpackage

// File: rtl/aska_spi_hdr_rx.sv
// rtl/aska_spi_hdr_rx.sv - rising-edge frame bit counter and header shift register
module aska_spi_hdr_rx
  import aska_spi_readback_pkg::*;
(
  input  logic                SPI_Clk,
  input  logic                frame_rst_n,
  input  logic                SPI_MOSI,
  output logic [CNT_W-1:0]    rx_cnt,
  output logic [HDR_BITS-1:0] hdr_sr
);

  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [HDR_BITS-1:0] hdr_sr_q, hdr_sr_d;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    hdr_sr_d = hdr_sr_q;
    // Saturate so an over-long frame can never wrap back into the header window.
    if (rx_cnt_q != {CNT_W{1'b1}}) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
    end
    if (rx_cnt_q < CNT_W'(HDR_BITS)) begin
      hdr_sr_d = {hdr_sr_q[HDR_BITS-2:0], SPI_MOSI};
    end
  end

  always_ff @(posedge SPI_Clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      rx_cnt_q <= '0;
      hdr_sr_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      hdr_sr_q <= hdr_sr_d;
    end
  end

  assign rx_cnt = rx_cnt_q;
  assign hdr_sr = hdr_sr_q;

endmodule

// File: rtl/aska_spi_readback.sv
// rtl/aska_spi_readback.sv - MISO readback of one addressed ASIC's configuration registers
module aska_spi_readback
  import aska_spi_readback_pkg::*;
(
  input  logic                 SPI_Clk,
  input  logic                 resetn,
  input  logic                 SPI_CS,
  input  logic                 SPI_MOSI,
  input  logic [1:0]           IC_addr,
  input  logic [DATA_BITS-1:0] conf0,
  input  logic [DATA_BITS-1:0] conf1,
  input  logic [DATA_BITS-1:0] ele1,
  input  logic [DATA_BITS-1:0] ele2,
  output logic                 SPI_MISO,
  output logic                 SPI_MISO_oe,
  output logic [7:0]           rd_frame_cnt
);

  // CS high acts as an asynchronous frame clear alongside the global reset.
  logic frame_rst_n;
  assign frame_rst_n = resetn & ~SPI_CS;

  logic [CNT_W-1:0]    rx_cnt;
  logic [HDR_BITS-1:0] hdr_sr;

  aska_spi_hdr_rx u_hdr_rx (
    .SPI_Clk     (SPI_Clk),
    .frame_rst_n (frame_rst_n),
    .SPI_MOSI    (SPI_MOSI),
    .rx_cnt      (rx_cnt),
    .hdr_sr      (hdr_sr)
  );

  logic unused_hdr_rsvd;
  assign unused_hdr_rsvd = ^hdr_sr[RD_BIT-1:REG_MSB+1];

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
  logic                 sel_rd_q, sel_rd_d;
  logic [7:0]           rd_frame_cnt_q, rd_frame_cnt_d;

  always_comb begin
    state_d  = state_q;
    tx_sr_d  = tx_sr_q;
    sel_rd_d = sel_rd_q;
    case (state_q)
      ST_HDR: begin
        if (rx_cnt == CNT_W'(HDR_BITS)) begin
          if (hdr_selects_read(hdr_sr, IC_addr)) begin
            // Registers are quasi-static, so a single sample at load time is safe.
            case (hdr_sr[REG_MSB:REG_LSB])
              REG_CONF0: tx_sr_d = conf0;
              REG_CONF1: tx_sr_d = conf1;
              REG_ELE1:  tx_sr_d = ele1;
              default:   tx_sr_d = ele2;
            endcase
            sel_rd_d = 1'b1;
            state_d  = ST_TX;
          end else begin
            state_d = ST_IGN;
          end
        end
      end
      ST_TX: begin
        if (rx_cnt == CNT_W'(FRAME_BITS)) begin
          state_d = ST_DONE;
        end else begin
          tx_sr_d = {tx_sr_q[DATA_BITS-2:0], 1'b0};
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_IGN:  state_d = ST_IGN;
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(negedge SPI_Clk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q  <= ST_HDR;
      tx_sr_q  <= '0;
      sel_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      sel_rd_q <= sel_rd_d;
    end
  end

  // Counted on the edge where the master samples bit0, so truncated frames never count.
  always_comb begin
    rd_frame_cnt_d = rd_frame_cnt_q;
    if (sel_rd_q && (rx_cnt == CNT_W'(FRAME_BITS - 1))) begin
      rd_frame_cnt_d = rd_frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge SPI_Clk or negedge resetn) begin
    if (!resetn) begin
      rd_frame_cnt_q <= 8'd0;
    end else begin
      rd_frame_cnt_q <= rd_frame_cnt_d;
    end
  end

  assign SPI_MISO_oe  = (state_q == ST_TX);
  assign SPI_MISO     = (state_q == ST_TX) ? tx_sr_q[DATA_BITS-1] : 1'b0;
  assign rd_frame_cnt = rd_frame_cnt_q;

endmodule

// File: tb/tb_aska_spi_readback.sv
// tb/tb_aska_spi_readback.sv - self-checking bench for aska_spi_readback
module tb_aska_spi_readback;

  logic        SPI_Clk;
  logic        resetn;
  logic        SPI_CS;
  logic        SPI_MOSI;
  logic [1:0]  ic_addr;
  logic [31:0] regs [4];
  logic        SPI_MISO;
  logic        SPI_MISO_oe;
  logic [7:0]  rd_frame_cnt;

  int          n_asserts;
  int          n_fail;
  logic [7:0]  exp_cnt;

  aska_spi_readback dut (
    .SPI_Clk      (SPI_Clk),
    .resetn       (resetn),
    .SPI_CS       (SPI_CS),
    .SPI_MOSI     (SPI_MOSI),
    .IC_addr      (ic_addr),
    .conf0        (regs[0]),
    .conf1        (regs[1]),
    .ele1         (regs[2]),
    .ele2         (regs[3]),
    .SPI_MISO     (SPI_MISO),
    .SPI_MISO_oe  (SPI_MISO_oe),
    .rd_frame_cnt (rd_frame_cnt)
  );

  initial SPI_Clk = 1'b0;
  always #10 SPI_Clk = ~SPI_Clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected pins just before rising edge k: bit (40-k) of the word is on MISO for k in 9..40.
  task automatic check_pins(input string tag, input int k, input bit sel, input logic [31:0] data);
    bit   act;
    logic exp_miso;
    act      = sel && (k >= 9) && (k <= 40);
    exp_miso = act ? data[40-k] : 1'b0;
    check($sformatf("%s k%0d oe", tag, k), 32'(SPI_MISO_oe), 32'(act));
    check($sformatf("%s k%0d miso", tag, k), 32'(SPI_MISO), 32'(exp_miso));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] hdr, input int n, input int rst_at);
    bit          sel;
    logic [31:0] data;
    sel  = (hdr[7:6] == ic_addr) && hdr[5];
    data = regs[hdr[1:0]];
    @(negedge SPI_Clk);
    #1;
    SPI_CS = 1'b0;
    for (int k = 1; k <= n; k++) begin
      SPI_MOSI = (k <= 8) ? hdr[8-k] : 1'($urandom);
      #2;
      check_pins(tag, k, sel, data);
      if (k == rst_at) begin
        resetn = 1'b0;
        #1;
        exp_cnt = 8'd0;
        check({tag, " rst oe"}, 32'(SPI_MISO_oe), 32'd0);
        check({tag, " rst miso"}, 32'(SPI_MISO), 32'd0);
        check({tag, " rst cnt"}, 32'(rd_frame_cnt), 32'(exp_cnt));
        SPI_CS = 1'b1;
        #1;
        resetn = 1'b1;
        @(negedge SPI_Clk);
        return;
      end
      @(posedge SPI_Clk);
      @(negedge SPI_Clk);
    end
    #2;
    check_pins(tag, n + 1, sel, data);
    if (sel && n >= 40) exp_cnt = exp_cnt + 8'd1;
    check({tag, " cnt"}, 32'(rd_frame_cnt), 32'(exp_cnt));
    SPI_CS = 1'b1;
    #1;
    check({tag, " cs oe"}, 32'(SPI_MISO_oe), 32'd0);
    check({tag, " cs miso"}, 32'(SPI_MISO), 32'd0);
    @(negedge SPI_Clk);
  endtask

  initial begin
    logic [7:0] hdr;
    n_asserts = 0;
    n_fail    = 0;
    exp_cnt   = 8'd0;
    resetn    = 1'b0;
    SPI_CS    = 1'b1;
    SPI_MOSI  = 1'b0;
    ic_addr   = 2'd2;
    for (int r = 0; r < 4; r++) regs[r] = $urandom;

    repeat (2) @(negedge SPI_Clk);
    check("reset miso", 32'(SPI_MISO), 32'd0);
    check("reset oe", 32'(SPI_MISO_oe), 32'd0);
    check("reset cnt", 32'(rd_frame_cnt), 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge SPI_Clk);

    regs[1] = 32'hDEADBEEF;
    run_frame("conf1", 8'hA1, 40, 0);

    ic_addr = 2'd1;
    regs[3] = 32'h0000_0001;
    run_frame("other_ic", 8'hA3, 40, 0);

    ic_addr = 2'd2;
    run_frame("write_hdr", 8'h82, 40, 0);
    run_frame("short", 8'hA1, 5, 0);

    regs[0] = 32'h12345678;
    run_frame("cs_abort", 8'hA0, 20, 0);
    run_frame("conf0", 8'hA0, 40, 0);

    for (int i = 0; i < 256; i++) begin
      ic_addr = 2'($urandom);
      for (int r = 0; r < 4; r++) regs[r] = $urandom;
      hdr = {ic_addr, 1'b1, 3'($urandom), 2'($urandom)};
      run_frame($sformatf("b2b%0d", i), hdr, 40, 0);
    end

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < 4; r++) regs[r] = $urandom;
      hdr = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), hdr, int'($urandom_range(1, 44)), 0);
    end

    ic_addr = 2'd3;
    regs[2] = $urandom;
    run_frame("long44", 8'hE2, 44, 0);

    run_frame("rst15", 8'hE2, 40, 15);
    regs[3] = $urandom;
    run_frame("post_rst", 8'hE3, 40, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/aska_spi_readback.md
Name: aska_spi_readback

Overview:
- MISO transmit path for the ASKA SPI slave. Lets the SPI master read back the four 32-bit configuration registers (conf0, conf1, ele1, ele2) of one addressed ASIC on a bus shared by up to 4 devices.
- Sits downstream of the configuration write receiver: it consumes that receiver's output registers and drives SPI_MISO with a per-IC tri-state enable.
- Runs entirely on SPI_Clk, with SPI_CS as an asynchronous frame clear.

Parameters:
- HDR_BITS, 8, header length in bits.
- DATA_BITS, 32, payload length in bits.
- FRAME_BITS, 40, total frame length (HDR_BITS+DATA_BITS).

Ports:
- SPI_Clk  input  1  SPI clock, mode 0: master samples MISO on rising edge; this block updates MISO on falling edge.
- resetn  input  1  asynchronous, active-low reset.
- SPI_CS  input  1  chip select, active low. High asynchronously clears all frame state.
- SPI_MOSI  input  1  master data; header bits sampled on rising edge.
- IC_addr  input  2  strap address of this IC.
- conf0  input  32  readback source for reg_addr 00.
- conf1  input  32  readback source for reg_addr 01.
- ele1  input  32  readback source for reg_addr 10.
- ele2  input  32  readback source for reg_addr 11.
- SPI_MISO  output  1  serial read data, MSB first.
- SPI_MISO_oe  output  1  pad tri-state enable, high only while this IC is transmitting.
- rd_frame_cnt  output  8  count of completed read frames, wraps at 255->0.

Behaviour:
- Clock and reset: clock SPI_Clk; reset resetn, asynchronous, active-low.
- Header format, MSB first:
  - bit7:6 = IC address.
  - bit5 = RD (1 = read frame).
  - bit4:2 = reserved, ignored.
  - bit1:0 = reg_addr.
- Companion requirement: the write receiver must qualify writes with header bit5 = 0, so read frames never update registers.
- Rising-edge domain (clear: resetn low or SPI_CS high; resetn-only items noted):
  - rx_cnt (6b): increments each rising edge while SPI_CS low; saturates at 63.
  - hdr_sr (8b): shifts in SPI_MOSI while rx_cnt < 8.
  - rd_frame_cnt: cleared by resetn only. Increments by 1 on the rising edge where rx_cnt goes 39->40, if the frame is a selected read (sel_rd latched).
- Falling-edge domain FSM (clear to HDR on resetn low or SPI_CS high). States:
  - HDR: SPI_MISO=0, oe=0. On the first falling edge with rx_cnt==8:
    - If hdr_sr[7:6]==IC_addr and hdr_sr[5]==1: load tx_sr with the register selected by hdr_sr[1:0], set sel_rd, go to TX.
    - Otherwise go to IGN.
  - TX: SPI_MISO=tx_sr[31], oe=1. Each subsequent falling edge shifts tx_sr left, filling 0. On the falling edge with rx_cnt==40, go to DONE.
  - DONE: SPI_MISO=0, oe=0. Holds until SPI_CS high; extra clocks are ignored.
  - IGN: SPI_MISO=0, oe=0. Holds until SPI_CS high.
- Timing:
  - Register bit31 is valid on MISO from the falling edge after rising edge 8, so the master samples it on rising edge 9.
  - Bit0 is sampled on rising edge 40.
  - Latency from header complete to first data bit: half an SPI_Clk.
- CDC:
  - conf*/ele* are sampled once, at the load edge. They are quasi-static: they change only from a prior write frame plus 2 internal clk cycles.
  - The master must allow at least 3 internal clk periods (150 us at 20 kHz) between a write and a readback of the same register. No synchroniser is used in this block.
- Boundary conditions:
  - CS rising mid-frame (rx_cnt < 40): FSM returns to HDR, oe drops immediately (asynchronously), rd_frame_cnt is unchanged.
  - Frame with fewer than 8 clocks: stays in HDR, oe never asserted.
  - resetn low at any time: all state cleared, SPI_MISO=0, oe=0, rd_frame_cnt=0.
- Reset values: SPI_MISO=0, SPI_MISO_oe=0, rd_frame_cnt=0.

Decomposition:
- Shared package holds:
  - constants HDR_BITS, DATA_BITS, FRAME_BITS;
  - header bit positions (IC_ADDR_MSB=7, IC_ADDR_LSB=6, RD_BIT=5, REG_MSB=1, REG_LSB=0);
  - reg_addr encodings REG_CONF0=0, REG_CONF1=1, REG_ELE1=2, REG_ELE2=3;
  - FSM state encoding HDR/TX/DONE/IGN.
- One sub-module: aska_spi_hdr_rx (rising-edge rx_cnt + hdr_sr). The write receiver can later share it.

Test Plan:
- conf1=32'hDEADBEEF, IC_addr=2, header 8'hA1, 40 clocks -> MISO shifts 0xDEADBEEF on rising edges 9..40; oe high only in that span; rd_frame_cnt=1.
- ele2=32'h0000_0001, header 8'hA3 (IC 2), IC_addr=1 -> oe stays 0 for the full frame, MISO=0, rd_frame_cnt unchanged.
- Header 8'h82 (RD=0, IC 2), IC_addr=2 -> IGN state, oe=0 throughout, rd_frame_cnt unchanged.
- Read conf0=32'h12345678, raise CS after 20 clocks -> oe falls asynchronously with CS; the next full read frame returns 0x12345678 correctly; rd_frame_cnt increments only for the full frame.
- 256 back-to-back valid reads -> rd_frame_cnt wraps to 0; 44 clocks in one frame -> MISO=0, oe=0 after clock 40.
- Assert resetn low at clock 15 of a read frame -> SPI_MISO=0, oe=0, rd_frame_cnt=0 immediately; after release, the next frame behaves normally.
